// File: rtl/bcd_subtractor_serial.sv
// Digit-serial n-digit BCD subtractor: D = X - Y, one digit per clock, LSD first.
// Produces a ten's-complement result with b_out=1 when X < Y; invalid digits force D=0 and err=1.
module bcd_subtractor_serial #(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [4*n-1:0] X,
    input  logic [4*n-1:0] Y,
    output logic [4*n-1:0] D,
    output logic           b_out,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [4*n-1:0] x_reg, y_reg, work, work_nxt;
    logic [IW-1:0]  idx;
    logic [IW+1:0]  base;
    logic           borrow, borrow_nxt, bad, last;
    logic [3:0]     xd, yd, dig;
    logic signed [4:0] t;

    function automatic logic has_bad_digit(input logic [4*n-1:0] v);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One digit of the borrow chain; 5-bit signed holds x - y - b for any 4-bit digits.
    always_comb begin
        base       = {idx, 2'b00};
        last       = (idx == IW'(n - 1));
        xd         = x_reg[base +: 4];
        yd         = y_reg[base +: 4];
        t          = $signed({1'b0, xd}) - $signed({1'b0, yd}) - $signed({4'b0000, borrow});
        dig        = t[3:0];
        borrow_nxt = 1'b0;
        if (t[4]) begin
            dig        = t[3:0] + 4'd10;
            borrow_nxt = 1'b1;
        end
        work_nxt            = work;
        work_nxt[base +: 4] = dig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            x_reg  <= '0;
            y_reg  <= '0;
            work   <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            bad    <= 1'b0;
            D      <= '0;
            b_out  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (start) begin
                    x_reg  <= X;
                    y_reg  <= Y;
                    work   <= '0;
                    idx    <= '0;
                    borrow <= 1'b0;
                    bad    <= has_bad_digit(X) | has_bad_digit(Y);
                end
                CALC: begin
                    work   <= work_nxt;
                    borrow <= borrow_nxt;
                    if (last) begin
                        D     <= bad ? '0 : work_nxt;
                        b_out <= bad ? 1'b0 : borrow_nxt;
                        err   <= bad;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Directed bench for bcd_subtractor_serial (n=4): hand-computed BCD differences,
// cycle-exact busy/done timing, invalid digits, ignored starts and mid-operation reset.
module tb_bcd_subtractor_serial;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] X, Y, D;
    logic        b_out, busy, done, err;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt;

    bcd_subtractor_serial #(.n(4)) dut (
        .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y),
        .D(D), .b_out(b_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is driven 1 time unit after an edge, so the next edge is the start edge.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp_d, input logic exp_b, input logic exp_e);
        X = x; Y = y; start = 1'b1;
        tick();
        start = 1'b0;
        X = 16'hFFFF; Y = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("busy_calc%0d_%h", i, x), busy, 1'b1);
            check($sformatf("done_calc%0d_%h", i, x), done, 1'b0);
            tick();
        end
        check($sformatf("done_%h_%h", x, y), done, 1'b1);
        check($sformatf("busy_done_%h", x), busy, 1'b0);
        check($sformatf("D_%h_%h", x, y), D, exp_d);
        check($sformatf("bout_%h_%h", x, y), b_out, exp_b);
        check($sformatf("err_%h_%h", x, y), err, exp_e);
        tick();
        check($sformatf("done_clear_%h", x), done, 1'b0);
        check($sformatf("D_hold_%h", x), D, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; X = '0; Y = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_D", D, 16'h0);
        check("rst_bout", b_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);

        run_op(16'h4355, 16'h2509, 16'h1846, 1'b0, 1'b0);
        run_op(16'h0434, 16'h8885, 16'h1549, 1'b1, 1'b0);
        run_op(16'h2250, 16'h4067, 16'h8183, 1'b1, 1'b0);
        run_op(16'h8573, 16'h6636, 16'h1937, 1'b0, 1'b0);
        run_op(16'h1111, 16'h1111, 16'h0000, 1'b0, 1'b0);
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
        run_op(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0);
        run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1);
        run_op(16'h0005, 16'h000B, 16'h0000, 1'b0, 1'b1);
        run_op(16'h0050, 16'h0007, 16'h0043, 1'b0, 1'b0);

        // Start held high through CALC and DONE: only the first request counts.
        X = 16'h4355; Y = 16'h2509; start = 1'b1;
        tick();
        X = 16'h9999; Y = 16'h0000;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("ign_done_pulses", done_cnt, 1);
        check("ign_busy_after_done", busy, 1'b0);
        check("ign_done_after_done", done, 1'b0);
        check("ign_D", D, 16'h1846);
        tick();
        start = 1'b0;
        check("accept_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("accept_D_before", D, 16'h1846);
        tick();
        check("accept_done", done, 1'b1);
        check("accept_D", D, 16'h9999);
        tick();

        // Reset during the second CALC cycle aborts without a done pulse.
        X = 16'h0434; Y = 16'h8885; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_D", D, 16'h0);
        check("abort_bout", b_out, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("abort_no_activity", done_cnt, 0);
        run_op(16'h2250, 16'h4067, 16'h8183, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
